// File: rtl/ravenoc_pkg.sv
// Shared NoC types and sizing for the TX packet scheduler and its neighbours.
package ravenoc_pkg;

  localparam int unsigned NumVirtChn    = 3;
  localparam int unsigned FlitDataWidth = 32;
  localparam int unsigned PktWidth      = 8;
  localparam int unsigned VcIdWidth     = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

  typedef struct packed {
    logic                     valid;
    logic                     req_new;
    logic                     req_last;
    logic [FlitDataWidth-1:0] flit_data_width;
    logic [PktWidth-1:0]      pkt_sz;
    logic [VcIdWidth-1:0]     vc_id;
  } s_pkt_out_req_t;

  typedef struct packed {
    logic ready;
  } s_pkt_out_resp_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_sched_st_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins,
// wrapping to the lowest requester overall when none is found above ptr.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  always_comb begin
    mask   = ~((N'(1) << ptr) - N'(1));
    masked = req & mask;
    pick   = (|masked) ? masked : req;
    // isolate lowest set bit of the chosen vector
    gnt    = pick & (~pick + N'(1));
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// Packet-level TX scheduler: round-robin over VCs, grant locked for a whole
// packet, head/tail framing generated from a per-packet flit counter.
module pkt_tx_sched
  import ravenoc_pkg::*;
#(
  parameter int unsigned N_VC    = NumVirtChn,
  parameter int unsigned FLIT_DW = FlitDataWidth,
  parameter int unsigned PKT_W   = PktWidth
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [N_VC-1:0]         vc_valid_i,
  input  logic [N_VC*FLIT_DW-1:0] vc_flit_i,
  input  logic [N_VC*PKT_W-1:0]   vc_pkt_sz_i,
  output logic [N_VC-1:0]         vc_pop_o,
  output s_pkt_out_req_t          pkt_out_req_o,
  input  s_pkt_out_resp_t         pkt_out_resp_i,
  output logic                    busy_o
);

  localparam int unsigned VC_W = VcIdWidth;

  tx_sched_st_t     state_q, state_d;
  logic [VC_W-1:0]  grant_q, grant_d;
  logic [VC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PKT_W-1:0] cnt_q, cnt_d;
  logic [PKT_W-1:0] sz_q, sz_d;

  logic [FLIT_DW-1:0] flit_arr [N_VC];
  logic [PKT_W-1:0]   sz_arr   [N_VC];
  logic [N_VC-1:0]    arb_gnt;
  logic [VC_W-1:0]    arb_idx;

  always_comb begin
    for (int i = 0; i < N_VC; i++) begin
      flit_arr[i] = vc_flit_i[i*FLIT_DW +: FLIT_DW];
      sz_arr[i]   = vc_pkt_sz_i[i*PKT_W +: PKT_W];
    end
  end

  rr_arbiter #(.N(N_VC), .IW(VC_W)) u_arb (
    .req (vc_valid_i),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= TX_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      sz_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      sz_q     <= sz_d;
    end
  end

  // Next state, framing and pop strobe; outputs stay 0 outside a valid SEND beat.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    sz_d          = sz_q;
    pkt_out_req_o = '0;
    vc_pop_o      = '0;
    case (state_q)
      TX_IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_idx;
          sz_d    = sz_arr[arb_idx];
          cnt_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (vc_valid_i[grant_q]) begin
          pkt_out_req_o.valid           = 1'b1;
          pkt_out_req_o.req_new         = (cnt_q == '0);
          pkt_out_req_o.req_last        = (cnt_q == sz_q);
          pkt_out_req_o.flit_data_width = flit_arr[grant_q];
          pkt_out_req_o.pkt_sz          = sz_q;
          pkt_out_req_o.vc_id           = grant_q;
          if (pkt_out_resp_i.ready) begin
            vc_pop_o = N_VC'(1) << grant_q;
            if (cnt_q == sz_q) begin
              state_d  = TX_IDLE;
              rr_ptr_d = (grant_q == VC_W'(N_VC-1)) ? '0 : grant_q + VC_W'(1);
            end else begin
              cnt_d = cnt_q + PKT_W'(1);
            end
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign busy_o = (state_q == TX_SEND);

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed and randomized bench for pkt_tx_sched against a packet-level reference model.
module tb_pkt_tx_sched;
  import ravenoc_pkg::*;

  localparam int unsigned N  = NumVirtChn;
  localparam int unsigned DW = FlitDataWidth;
  localparam int unsigned PW = PktWidth;

  logic            clk = 1'b0;
  logic            arst;
  logic [N-1:0]    vc_valid;
  logic [N*DW-1:0] vc_flit;
  logic [N*PW-1:0] vc_sz;
  logic [N-1:0]    vc_pop;
  s_pkt_out_req_t  req;
  s_pkt_out_resp_t resp;
  logic            busy;

  always #5 clk = ~clk;

  pkt_tx_sched dut (
    .clk            (clk),
    .arst           (arst),
    .vc_valid_i     (vc_valid),
    .vc_flit_i      (vc_flit),
    .vc_pkt_sz_i    (vc_sz),
    .vc_pop_o       (vc_pop),
    .pkt_out_req_o  (req),
    .pkt_out_resp_i (resp),
    .busy_o         (busy)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: which packet is in flight, how far along, and whose turn is next
  bit m_busy;
  int m_grant, m_cnt, m_sz, m_ptr;

  s_pkt_out_req_t obs_req;
  logic [N-1:0]   obs_pop;
  logic           obs_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_grant = 0; m_cnt = 0; m_sz = 0; m_ptr = 0;
  endtask

  task automatic set_vc(input int i, input bit v, input logic [DW-1:0] f, input int sz);
    vc_valid[i]         = v;
    vc_flit[i*DW +: DW] = f;
    vc_sz[i*PW +: PW]   = PW'(sz);
  endtask

  function automatic s_pkt_out_req_t model_req();
    s_pkt_out_req_t e;
    e = '0;
    if (arst && m_busy && vc_valid[m_grant]) begin
      e.valid           = 1'b1;
      e.req_new         = (m_cnt == 0);
      e.req_last        = (m_cnt == m_sz);
      e.flit_data_width = vc_flit[m_grant*DW +: DW];
      e.pkt_sz          = PW'(m_sz);
      e.vc_id           = VcIdWidth'(m_grant);
    end
    return e;
  endfunction

  // one clock: compare at negedge, advance model with the same inputs, return at posedge+1
  task automatic step(input string tag);
    s_pkt_out_req_t e_req;
    logic [N-1:0]   e_pop;
    bit             found;
    @(negedge clk);
    e_req = model_req();
    e_pop = '0;
    if (e_req.valid && resp.ready) e_pop[m_grant] = 1'b1;
    obs_req  = req;
    obs_pop  = vc_pop;
    obs_busy = busy;
    chk({tag, "_req"},  64'(obs_req),  64'(e_req));
    chk({tag, "_pop"},  64'(obs_pop),  64'(e_pop));
    chk({tag, "_busy"}, 64'(obs_busy), 64'(arst && m_busy));
    if (!arst) begin
      model_reset();
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && vc_valid[idx]) begin
          found   = 1;
          m_grant = idx;
          m_sz    = int'(vc_sz[idx*PW +: PW]);
          m_cnt   = 0;
          m_busy  = 1;
        end
      end
    end else if (vc_valid[m_grant] && resp.ready) begin
      if (m_cnt == m_sz) begin
        m_busy = 0;
        m_ptr  = (m_grant + 1) % N;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst = 1'b0; vc_valid = '0; vc_flit = '0; vc_sz = '0; resp = '0;
    model_reset();
    #1;
    chk("rst_req",  64'(req),    64'(0));
    chk("rst_pop",  64'(vc_pop), 64'(0));
    chk("rst_busy", 64'(busy),   64'(0));
    @(posedge clk); @(posedge clk); #1;
    arst = 1'b1;
    resp.ready = 1'b1;

    // 1: VC1, three-flit packet
    set_vc(1, 1, 32'hA, 2);
    step("t1_bubble");
    chk("t1_bubble_busy", 64'(obs_busy), 64'(0));
    step("t1_head");
    chk("t1_head_pop", 64'(obs_pop), 64'(3'b010));
    chk("t1_head_new", 64'({obs_req.req_new, obs_req.req_last, obs_req.vc_id, obs_req.pkt_sz}),
        64'({1'b1, 1'b0, 2'd1, 8'd2}));
    set_vc(1, 1, 32'hB, 2);
    step("t1_body");
    set_vc(1, 1, 32'hC, 2);
    step("t1_tail");
    chk("t1_tail_last", 64'({obs_req.req_last, obs_req.flit_data_width}), 64'({1'b1, 32'hC}));
    vc_valid = '0;
    step("t1_idle");
    chk("t1_idle_busy", 64'(obs_busy), 64'(0));

    // 2: head-only packet on VC0
    set_vc(0, 1, 32'h11, 0);
    step("t2_bubble");
    step("t2_head");
    chk("t2_new_last", 64'({obs_req.req_new, obs_req.req_last, obs_pop}), 64'({2'b11, 3'b001}));
    vc_valid = '0;
    step("t2_idle");

    // reset so the round-robin pointer starts at 0
    arst = 1'b0;
    step("rst2");
    arst = 1'b1;

    // 3: VC0 and VC2 contend
    set_vc(0, 1, 32'h20, 1);
    set_vc(2, 1, 32'h22, 1);
    step("t3_bub0");
    step("t3_v0_h");
    chk("t3_first_vc", 64'(obs_req.vc_id), 64'(0));
    step("t3_v0_t");
    vc_valid[0] = 1'b0;
    step("t3_bub2");
    step("t3_v2_h");
    chk("t3_second_vc", 64'(obs_req.vc_id), 64'(2));
    step("t3_v2_t");
    set_vc(0, 1, 32'h30, 0);
    set_vc(2, 1, 32'h32, 0);
    step("t3_bub");
    step("t3_wrap");
    chk("t3_ptr_wrapped", 64'(obs_req.vc_id), 64'(0));
    vc_valid = '0;
    step("t3_idle");

    // 4: backpressure on the body flit
    set_vc(1, 1, 32'h40, 2);
    step("t4_bubble");
    step("t4_head");
    set_vc(1, 1, 32'h41, 2);
    resp.ready = 1'b0;
    for (int i = 0; i < 3; i++) step("t4_stall");
    chk("t4_stall_pop", 64'(obs_pop), 64'(0));
    resp.ready = 1'b1;
    step("t4_body");
    chk("t4_body_pop", 64'(obs_pop), 64'(3'b010));
    set_vc(1, 1, 32'h42, 2);
    step("t4_tail");
    vc_valid = '0;
    step("t4_idle");

    // 5: underrun on the granted VC while VC2 waits
    set_vc(0, 1, 32'h50, 2);
    step("t5_bubble");
    step("t5_head");
    vc_valid[0] = 1'b0;
    set_vc(2, 1, 32'h52, 0);
    step("t5_gap0");
    step("t5_gap1");
    chk("t5_gap_req", 64'(obs_req), 64'(0));
    vc_valid[0] = 1'b1;
    step("t5_body");
    step("t5_tail");
    vc_valid[0] = 1'b0;
    step("t5_bub2");
    step("t5_vc2");
    chk("t5_vc2_id", 64'(obs_req.vc_id), 64'(2));
    vc_valid = '0;
    step("t5_idle");

    // 6: asynchronous reset mid-packet
    set_vc(1, 1, 32'h60, 2);
    step("t6_bubble");
    step("t6_head");
    #2 arst = 1'b0;
    #1;
    chk("t6_async_req",  64'(req),    64'(0));
    chk("t6_async_pop",  64'(vc_pop), 64'(0));
    chk("t6_async_busy", 64'(busy),   64'(0));
    model_reset();
    @(posedge clk); #1;
    arst = 1'b1;
    step("t6_bubble2");
    step("t6_head2");
    chk("t6_restart_new", 64'(obs_req.req_new), 64'(1));
    vc_valid = '0;
    step("t6_idle");

    // randomized traffic, backpressure and underruns
    for (int c = 0; c < 400; c++) begin
      vc_valid   = N'($urandom);
      vc_flit    = {$urandom, $urandom, $urandom};
      for (int i = 0; i < N; i++) vc_sz[i*PW +: PW] = PW'($urandom_range(0, 3));
      resp.ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
